display_frame_loader: RTL

Upstream stage of display_memory. Consumes the byte stream from the SPI slave (data/valid/sot/eot) and packs bytes into pixels. Writes each pixel into the back buffer at row-major addresses. On a correctly sized frame it waits for the driver's safe_flip and then toggles the buffer-select line feeding display_memory.

---
 rtl/display_frame_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/display_frame_loader.sv
// display_frame_loader: packs SPI bytes into pixels, writes them row-major into the back buffer and flips buffers on complete frames
// Ports: clk system clock; rst async active-low reset; data/valid/sot/eot byte stream from the SPI slave;
//   safe_flip swap permission from the display driver; wen/wrow/wcol/wdata back-buffer write port;
//   flip buffer-select level; busy high in LOAD or WAIT_FLIP; frame_done/err one-cycle status pulses
module display_frame_loader #(
   parameter int rows = 8,
   parameter int columns = 32,
   parameter int width = 24,
   parameter int bytes_per_pixel = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 data,
   input  logic                       valid,
   input  logic                       sot,
   input  logic                       eot,
   input  logic                       safe_flip,
   output logic                       wen,
   output logic [$clog2(rows)-1:0]    wrow,
   output logic [$clog2(columns)-1:0] wcol,
   output logic [width-1:0]           wdata,
   output logic                       flip,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       err
);
   localparam int total = rows * columns;
   localparam int pw = $clog2(total + 1);
   localparam int bw = $clog2(bytes_per_pixel + 1);
   localparam int rw = $clog2(rows);
   localparam int cw = $clog2(columns);
   typedef enum logic [1:0] {IDLE, LOAD, WAIT_FLIP} state_t;
   state_t state, state_d;
   logic [bw-1:0] byte_cnt, byte_d, byte_base, byte_inc;
   logic [pw-1:0] pix_cnt, pix_d, pix_base;
   logic [width-1:0] shift, shift_d, packed_pix;
   logic ovf, ovf_d, ovf_base, take, ok;
   logic wen_d, flip_d, busy_d, done_d, err_d;
   logic [rw-1:0] wrow_d;
   logic [cw-1:0] wcol_d;
   logic [width-1:0] wdata_d;
   always_comb begin
      state_d = state;
      byte_d = byte_cnt;
      pix_d = pix_cnt;
      shift_d = shift;
      ovf_d = ovf;
      wen_d = 1'b0;
      wrow_d = wrow;
      wcol_d = wcol;
      wdata_d = wdata;
      flip_d = flip;
      done_d = 1'b0;
      err_d = 1'b0;
      ok = 1'b0;
      packed_pix = width'({shift, data});
      // sot restarts the frame: the byte is counted against zeroed counters
      take = valid && (state == LOAD || (state == IDLE && sot));
      byte_base = sot ? '0 : byte_cnt;
      pix_base = sot ? '0 : pix_cnt;
      ovf_base = sot ? 1'b0 : ovf;
      byte_inc = byte_base + 1'b1;
      if (take) begin
         state_d = LOAD;
         byte_d = byte_base;
         pix_d = pix_base;
         ovf_d = ovf_base;
         if (pix_base == pw'(total)) ovf_d = 1'b1;
         else begin
            shift_d = packed_pix;
            byte_d = byte_inc == bw'(bytes_per_pixel) ? '0 : byte_inc;
            if (byte_inc == bw'(bytes_per_pixel)) begin
               wen_d = 1'b1;
               wdata_d = packed_pix;
               wrow_d = rw'(int'(pix_base) / columns);
               wcol_d = cw'(int'(pix_base) % columns);
               pix_d = pix_base + 1'b1;
            end
         end
      end
      // eot is judged on the counts after any byte taken in the same cycle
      if (state == LOAD && eot) begin
         ok = pix_d == pw'(total) && byte_d == '0 && !ovf_d;
         state_d = ok ? WAIT_FLIP : IDLE;
         err_d = !ok;
      end
      if (state == WAIT_FLIP && safe_flip) begin
         state_d = IDLE;
         flip_d = !flip;
         done_d = 1'b1;
      end
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         byte_cnt <= '0;
         pix_cnt <= '0;
         shift <= '0;
         ovf <= 1'b0;
         wen <= 1'b0;
         wrow <= '0;
         wcol <= '0;
         wdata <= '0;
         flip <= 1'b0;
         busy <= 1'b0;
         frame_done <= 1'b0;
         err <= 1'b0;
      end else begin
         state <= state_d;
         byte_cnt <= byte_d;
         pix_cnt <= pix_d;
         shift <= shift_d;
         ovf <= ovf_d;
         wen <= wen_d;
         wrow <= wrow_d;
         wcol <= wcol_d;
         wdata <= wdata_d;
         flip <= flip_d;
         busy <= busy_d;
         frame_done <= done_d;
         err <= err_d;
      end
   end
endmodule
